// File: rtl/tpu_top.sv
// -----------------------------------------------------------------------------
// tpu_top: NxN signed int8 matrix-multiply unit driven by a host.
//
// The host loads a weight matrix B (row-major beats) and an activation matrix
// A (addressed beats into a unified buffer), then issues MATRIX_MULTIPLY with
// the buffer base of A. A weight-stationary systolic array computes C = A*B;
// acc_row keeps the last row of C that left the array, i.e. C[N-1][*] once
// mmu_done has pulsed.
//
// Ports
//   clk                     clock, rising edge
//   reset_n                 asynchronous active-low reset
//   host_instruction_valid  instruction strobe
//   host_instruction        {opcode[31:29], imm[28:0]}
//   host_instruction_ready  high when an instruction would be accepted
//   host_write_data         signed data beat
//   host_wdata_valid        data beat strobe
//   host_write_address      unified-buffer byte address for activation beats
//   mmu_done                one-cycle pulse when acc_row holds the final row
// -----------------------------------------------------------------------------
module tpu_top #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int AW       = 32,
  parameter int UB_DEPTH = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          host_instruction_valid,
  input  logic [31:0]   host_instruction,
  output logic          host_instruction_ready,
  input  logic [DW-1:0] host_write_data,
  input  logic          host_wdata_valid,
  input  logic [11:0]   host_write_address,
  output logic          mmu_done
);

  typedef enum logic [2:0] {
    NOP              = 3'd0,
    READ_HOST_MEMORY = 3'd1,
    READ_WEIGHTS     = 3'd2,
    MATRIX_MULTIPLY  = 3'd3
  } tpu_instruction_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD_W  = 2'd1;
  localparam logic [1:0] ST_LOAD_UB = 2'd2;
  localparam logic [1:0] ST_MM_RUN  = 2'd3;

  localparam int PW = $clog2(N * N);
  localparam int TW = $clog2(3 * N);
  // Last run cycle: row N-1 leaves column N-1 of the array.
  localparam logic [TW-1:0] T_LAST = TW'(3 * N - 2);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [11:0]   base_q, base_d;
  logic [TW-1:0] t_q, t_d;
  logic          done_q, done_d;

  logic [DW-1:0] ub_mem [UB_DEPTH];

  logic signed [DW-1:0] w_q   [N][N];
  logic signed [DW-1:0] a_q   [N][N-1];
  logic signed [AW-1:0] p_q   [N][N];
  logic signed [DW-1:0] feed  [N];
  logic signed [DW-1:0] a_in  [N][N];
  logic signed [AW-1:0] p_in  [N][N];
  logic                 acc_en [N];

  logic signed [AW-1:0] acc_row [N];

  logic accept;
  logic w_wr, ub_wr;
  logic unused_imm;

  assign host_instruction_ready = reset_n && (state_q != ST_MM_RUN);
  assign accept   = host_instruction_valid && host_instruction_ready;
  assign w_wr     = host_wdata_valid && (state_q == ST_LOAD_W);
  assign ub_wr    = host_wdata_valid && (state_q == ST_LOAD_UB);
  assign mmu_done = done_q;
  assign unused_imm = ^host_instruction[28:12];

  // Control FSM. A beat arriving in the same cycle as an accepted instruction
  // still belongs to the old mode; the new opcode takes effect next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    t_d     = t_q;
    done_d  = 1'b0;
    if (state_q == ST_MM_RUN) begin
      t_d = t_q + 1'b1;
      if (t_q == T_LAST) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else begin
      if (w_wr) ptr_d = (ptr_q == PW'(N * N - 1)) ? '0 : ptr_q + 1'b1;
      if (accept) begin
        case (tpu_instruction_e'(host_instruction[31:29]))
          READ_WEIGHTS: begin
            state_d = ST_LOAD_W;
            ptr_d   = '0;
          end
          READ_HOST_MEMORY: state_d = ST_LOAD_UB;
          MATRIX_MULTIPLY: begin
            state_d = ST_MM_RUN;
            base_d  = host_instruction[11:0];
            t_d     = '0;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Skewed feed: row k of the array receives A[t-k][k] during run cycle t.
  // Outside the valid window a zero is injected so idle lanes add nothing.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      feed[k] = '0;
      if ((state_q == ST_MM_RUN) && (int'(t_q) - k >= 0) && (int'(t_q) - k < N))
        feed[k] = ub_mem[base_q + 12'((int'(t_q) - k) * N + k)];
    end
  end

  // PE(k,j): activation enters from the left, partial sum from above.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_in[k][0] = feed[k];
      for (int j = 1; j < N; j++) a_in[k][j] = a_q[k][j-1];
    end
    for (int j = 0; j < N; j++) begin
      p_in[0][j] = '0;
      for (int k = 1; k < N; k++) p_in[k][j] = p_q[k-1][j];
    end
  end

  // Bottom psum of column j during run cycle t belongs to row i = t - N - j.
  always_comb begin
    for (int j = 0; j < N; j++)
      acc_en[j] = (state_q == ST_MM_RUN) && (int'(t_q) - N - j >= 0)
                  && (int'(t_q) - N - j < N);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      base_q  <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        acc_row[k] <= '0;
        for (int j = 0; j < N; j++) begin
          w_q[k][j] <= '0;
          p_q[k][j] <= '0;
        end
        for (int j = 0; j < N - 1; j++) a_q[k][j] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      t_q     <= t_d;
      done_q  <= done_d;
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < N; j++) begin
          if (w_wr && (ptr_q == PW'(k * N + j))) w_q[k][j] <= host_write_data;
          // Sign-extend before multiplying; the sum wraps in AW bits.
          p_q[k][j] <= p_in[k][j] + AW'(a_in[k][j]) * AW'(w_q[k][j]);
        end
        for (int j = 0; j < N - 1; j++) a_q[k][j] <= a_in[k][j];
      end
      for (int j = 0; j < N; j++)
        if (acc_en[j]) acc_row[j] <= p_q[N-1][j];
    end
  end

  // NOTE: the unified buffer is deliberately not reset; reset leaves its contents intact.
  always_ff @(posedge clk) begin
    if (ub_wr) ub_mem[host_write_address] <= host_write_data;
  end

endmodule

// File: tb/tb_tpu_top.sv
// -----------------------------------------------------------------------------
// tb_tpu_top: directed self-checking bench for tpu_top. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tpu_top;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        host_instruction_valid;
  logic [31:0] host_instruction;
  logic        host_instruction_ready;
  logic [7:0]  host_write_data;
  logic        host_wdata_valid;
  logic [11:0] host_write_address;
  logic        mmu_done;

  int total = 0;
  int bad   = 0;

  int b_rows [16];   // B[k][j] = k+1
  int a_seq  [16];   // A = 1..16 row-major
  int a_neg  [16];   // rows 0..2 as a_seq, row 3 = -1..-4
  int b_eye  [16];   // identity
  int e_150  [4];
  int e_neg  [4];
  int e_wrap [4];
  int e_zero [4];

  tpu_top dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .host_instruction_valid (host_instruction_valid),
    .host_instruction       (host_instruction),
    .host_instruction_ready (host_instruction_ready),
    .host_write_data        (host_write_data),
    .host_wdata_valid       (host_wdata_valid),
    .host_write_address     (host_write_address),
    .mmu_done               (mmu_done)
  );

  always #5 clk = ~clk;

  task automatic instr(input logic [2:0] op, input logic [28:0] imm);
    host_instruction_valid = 1'b1;
    host_instruction       = {op, imm};
    @(negedge clk);
    host_instruction_valid = 1'b0;
    host_instruction       = '0;
  endtask

  task automatic beat(input int d, input int addr);
    host_wdata_valid   = 1'b1;
    host_write_data    = d[7:0];
    host_write_address = addr[11:0];
    @(negedge clk);
    host_wdata_valid   = 1'b0;
  endtask

  task automatic load_weights(input int vals [16], input bit gapped);
    instr(3'd2, '0);
    for (int i = 0; i < 16; i++) begin
      beat(vals[i], 0);
      if (gapped) repeat (2) @(negedge clk);
    end
  endtask

  task automatic load_a(input int base, input int vals [16], input bit gapped);
    instr(3'd1, '0);
    for (int i = 0; i < 16; i++) begin
      beat(vals[i], base + i);
      if (gapped) @(negedge clk);
    end
  endtask

  task automatic check_acc(input string name, input int exp [4]);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (dut.acc_row[j] !== exp[j]) begin
        bad++;
        $display("FAIL %s acc_row[%0d]: got %0d want %0d", name, j, $signed(dut.acc_row[j]), exp[j]);
      end
    end
  endtask

  // Issues MATRIX_MULTIPLY and watches 16 cycles: done must pulse exactly
  // once within 11 cycles of the acceptance edge. Optionally injects a second
  // MATRIX_MULTIPLY mid-run, which must be dropped.
  task automatic run_mm(input string name, input int base, input int exp [4], input bit inject);
    int first = 0;
    int pulses = 0;
    instr(3'd3, 29'(base));
    for (int cyc = 1; cyc <= 16; cyc++) begin
      host_instruction_valid = inject && (cyc == 3);
      host_instruction       = {3'd3, 29'd0};
      @(negedge clk);
      if (cyc == 1) begin
        total++;
        if (host_instruction_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s ready_in_run: got %b want 0", name, host_instruction_ready);
        end
      end
      if (mmu_done === 1'b1) begin
        pulses++;
        if (first == 0) first = cyc;
      end
    end
    host_instruction_valid = 1'b0;
    host_instruction       = '0;
    total++;
    if (first == 0 || first > 11) begin
      bad++;
      $display("FAIL %s latency: got %0d want 1..11 (0 = never)", name, first);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d want 1", name, pulses);
    end
    total++;
    if (host_instruction_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_after: got %b want 1", name, host_instruction_ready);
    end
    check_acc(name, exp);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    host_instruction_valid = 1'b0;
    host_instruction = '0;
    host_write_data = '0;
    host_wdata_valid = 1'b0;
    host_write_address = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (host_instruction_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset ready: got %b want 1", host_instruction_ready);
    end
    total++;
    if (mmu_done !== 1'b0) begin
      bad++;
      $display("FAIL reset mmu_done: got %b want 0", mmu_done);
    end
    check_acc("reset", e_zero);
  endtask

  // C[3][j] = 13*1 + 14*2 + 15*3 + 16*4 = 150 for every column.
  task automatic test_basic();
    load_weights(b_rows, 1'b1);
    load_a(0, a_seq, 1'b1);
    run_mm("basic", 0, e_150, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_weights(b_rows, 1'b0);
    load_a(0, a_seq, 1'b0);
    run_mm("b2b", 0, e_150, 1'b0);
    // A beat while IDLE must not touch A[3][0] at address 12.
    beat(99, 12);
    run_mm("idle_beat", 0, e_150, 1'b0);
  endtask

  task automatic test_negative();
    load_weights(b_eye, 1'b0);
    load_a(100, a_neg, 1'b1);
    run_mm("negative", 100, e_neg, 1'b0);
  endtask

  task automatic test_drop_and_wrap();
    int extra = 0;
    run_mm("drop", 100, e_neg, 1'b1);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (mmu_done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL drop extra_done: got %0d want 0", extra);
    end
    // 17th beat wraps the pointer and replaces W[0][0] with 5.
    instr(3'd2, '0);
    for (int i = 0; i < 16; i++) beat(b_eye[i], 0);
    beat(5, 0);
    run_mm("wrap", 100, e_wrap, 1'b0);
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    instr(3'd3, '0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_acc("abort_in_reset", e_zero);
    @(negedge clk);
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (mmu_done === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort done_pulses: got %0d want 0", pulses);
    end
    total++;
    if (host_instruction_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort ready: got %b want 1", host_instruction_ready);
    end
    check_acc("abort_after", e_zero);
    // Weights were cleared by reset; the buffer still holds A at base 0.
    load_weights(b_rows, 1'b0);
    run_mm("rerun", 0, e_150, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      b_rows[i] = i / 4 + 1;
      a_seq[i]  = i + 1;
      a_neg[i]  = (i < 12) ? i + 1 : -(i - 11);
      b_eye[i]  = (i / 4 == i % 4) ? 1 : 0;
    end
    e_150  = '{150, 150, 150, 150};
    e_neg  = '{-1, -2, -3, -4};
    e_wrap = '{-5, -2, -3, -4};
    e_zero = '{0, 0, 0, 0};

    test_reset();
    test_basic();
    test_back_to_back();
    test_negative();
    test_drop_and_wrap();
    test_reset_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
